multdiv_ctrl: RTL

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_ctrl_pkg.sv | 22 ++
 rtl/md_timeout_cnt.sv | 36 +++
 rtl/multdiv_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide pipeline controller.
//   md_state_t   : controller FSM encoding (also exported on the debug port)
//   RSTATUS_REG  : register that receives the status code on an exception
//   STATUS_MULT / STATUS_DIV : status codes written for mult / div exceptions
package multdiv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] STATUS_MULT = 32'd4;
    localparam logic [31:0] STATUS_DIV  = 32'd5;

    function automatic logic [31:0] status_code(input logic is_mult);
        return is_mult ? STATUS_MULT : STATUS_DIV;
    endfunction

endpackage

// File: rtl/md_timeout_cnt.sv
// WAIT-cycle watchdog counter for multdiv_ctrl (only built when
// MULTDIV_CTRL_TIMEOUT_EN is defined).
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   enable       : count one cycle (controller is in WAIT)
//   clear        : restart from zero (controller is about to enter WAIT)
//   limit_hit    : current cycle is the LIMIT-th WAIT cycle
module md_timeout_cnt #(
    parameter int LIMIT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic limit_hit
);

    localparam int W = $clog2(LIMIT + 1);

    // cnt holds the number of WAIT cycles already completed, so the exit
    // edge taken while limit_hit is high ends exactly LIMIT WAIT cycles.
    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !limit_hit) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign limit_hit = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Pipeline controller for a multi-cycle multiply/divide unit.
// Stalls the front of the pipeline while a mul/div in DX runs, launches the
// unit with a one-cycle start pulse and held operands, and issues a single
// writeback request when the unit reports completion.
// Optional feature: define MULTDIV_CTRL_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYCLES cycles with an exception completion and a sticky timeout_err.
// Ports:
//   clock, reset                    : rising-edge clock, async active-high reset
//   dx_is_mult, dx_is_div, dx_rd    : decoded instruction in DX
//   dx_opA, dx_opB                  : bypassed operands of that instruction
//   md_ctrl_mult, md_ctrl_div       : start pulses to the multdiv unit
//   md_opA, md_opB                  : operands held for the whole operation
//   md_result, md_exception, md_ready : completion from the multdiv unit
//   stall, busy                     : pipeline freeze / controller active
//   wb_valid, wb_rd, wb_data, wb_exception : writeback request
//   timeout_err                     : sticky watchdog flag
//   dbg_state                       : current FSM state
// Handshake: md_ready is a single-cycle completion strobe, only honoured in
// WAIT; md_exception/md_result are qualified by md_ready. wb_valid is a
// one-cycle request with no back-pressure.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dx_is_mult,
    input  logic        dx_is_div,
    input  logic [4:0]  dx_rd,
    input  logic [31:0] dx_opA,
    input  logic [31:0] dx_opB,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception,
    output logic        timeout_err,
    output md_state_t   dbg_state
);

    md_state_t  state;
    logic       op_mult;
    logic [4:0] op_rd;
    logic       timeout_hit;
    logic       start_req;
    logic       exc_path;

    assign start_req = dx_is_mult | dx_is_div;
    // A real completion wins over a coincident watchdog expiry.
    assign exc_path  = md_ready ? md_exception : 1'b1;

`ifdef MULTDIV_CTRL_TIMEOUT_EN
    logic cnt_en;
    logic cnt_clr;

    assign cnt_en  = (state == ST_WAIT);
    assign cnt_clr = (state == ST_START);

    md_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clock    (clock),
        .reset    (reset),
        .enable   (cnt_en),
        .clear    (cnt_clr),
        .limit_hit(timeout_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (state == ST_WAIT && timeout_hit && !md_ready) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_mult      <= 1'b0;
            op_rd        <= '0;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            md_opA       <= '0;
            md_opB       <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
        end else begin
            // Pulses and the writeback qualifiers default low each cycle;
            // wb_rd/wb_data keep their last values.
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_exception <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state        <= ST_START;
                        md_opA       <= dx_opA;
                        md_opB       <= dx_opB;
                        op_rd        <= dx_rd;
                        // mult has priority when both decodes are set
                        op_mult      <= dx_is_mult;
                        md_ctrl_mult <= dx_is_mult;
                        md_ctrl_div  <= ~dx_is_mult;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (md_ready || timeout_hit) begin
                        state <= ST_DONE;
                        if (exc_path) begin
                            wb_valid     <= 1'b1;
                            wb_rd        <= RSTATUS_REG;
                            wb_data      <= status_code(op_mult);
                            wb_exception <= 1'b1;
                        end else begin
                            // writes to r0 are dropped but DONE still happens
                            wb_valid <= (op_rd != 5'd0);
                            wb_rd    <= op_rd;
                            wb_data  <= md_result;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign stall     = ((state == ST_IDLE) && start_req) ||
                       (state == ST_START) || (state == ST_WAIT);
    assign dbg_state = state;

endmodule
